// File: rtl/rca_adder.sv
// Ripple-carry adder: WIDTH chained 1-bit full adders with combinational sum,
// carry-out and signed overflow, plus a one-cycle registered copy of each.

module rca_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic k_i,
    output logic s_o,
    output logic k_o
);

    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ k_i;
    assign k_o = (a_i & b_i) | (k_i & p);

endmodule

module rca_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf,
    output logic [WIDTH-1:0] s_q,
    output logic             c_q,
    output logic             ovf_q
);

    // k[i] is the carry into bit i; k[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0] k;

    assign k[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        rca_full_adder u_fa (
            .a_i (a[i]),
            .b_i (b[i]),
            .k_i (k[i]),
            .s_o (s[i]),
            .k_o (k[i+1])
        );
    end

    assign c   = k[WIDTH];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // With WIDTH = 1 this is k[1] ^ k[0], which reduces to c.
    assign ovf = k[WIDTH] ^ k[WIDTH-1];

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge value of its input, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q   <= '0;
            c_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            s_q   <= s;
            c_q   <= c;
            ovf_q <= ovf;
        end
    end

endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder: directed vector table, reset sequences,
// and random operands checked against an arithmetic reference model.

module tb_rca_adder;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_s;
        logic             exp_c;
        logic             exp_ovf;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] a   = '0;
    logic [WIDTH-1:0] b   = '0;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             ovf_q;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[8];

    always #10 clk = ~clk;

    rca_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
        .s     (s),
        .c     (c),
        .ovf   (ovf),
        .s_q   (s_q),
        .c_q   (c_q),
        .ovf_q (ovf_q)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact unsigned sum, and signed overflow from operand/result signs.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output logic [WIDTH-1:0] ms, output logic mc, output logic movf);
        logic [WIDTH:0] full;
        full = {1'b0, x} + {1'b0, y};
        ms   = full[WIDTH-1:0];
        mc   = full[WIDTH];
        movf = (x[WIDTH-1] == y[WIDTH-1]) && (ms[WIDTH-1] != x[WIDTH-1]);
    endtask

    // Drive just after a rising edge, check comb outputs 15 ns later,
    // then registered outputs just after the next rising edge.
    task automatic apply(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        #15;
        check({tag, " s"},   64'(s),   64'(es));
        check({tag, " c"},   64'(c),   64'(ec));
        check({tag, " ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk);
        #1;
        check({tag, " s_q"},   64'(s_q),   64'(es));
        check({tag, " c_q"},   64'(c_q),   64'(ec));
        check({tag, " ovf_q"}, 64'(ovf_q), 64'(eo));
    endtask

    initial begin
        logic [WIDTH-1:0] rs;
        logic             rc;
        logic             ro;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        vecs[0] = '{32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0};
        vecs[6] = '{32'h5555_5555, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1};

        // Reset takes effect before any clock edge.
        #1;
        rst = 1'b1;
        #2;
        check("reset s_q",   64'(s_q),   64'h0);
        check("reset c_q",   64'(c_q),   64'h0);
        check("reset ovf_q", 64'(ovf_q), 64'h0);

        // Reset dominates clock edges while held; comb path still live.
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        @(posedge clk);
        #1;
        check("held reset s_q", 64'(s_q), 64'h0);
        check("held reset c_q", 64'(c_q), 64'h0);
        check("comb in reset c", 64'(c),  64'h1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i])
            apply($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                  vecs[i].exp_s, vecs[i].exp_c, vecs[i].exp_ovf);

        // Mid-operation reset: regs clear at once, comb outputs unaffected,
        // first edge after release reloads the current sum.
        apply("pre-rst", 32'h0000_0005, 32'h0000_000A, 32'h0000_000F, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async rst s_q",   64'(s_q),   64'h0);
        check("async rst c_q",   64'(c_q),   64'h0);
        check("async rst ovf_q", 64'(ovf_q), 64'h0);
        check("async rst s",     64'(s),     64'h0000_000F);
        check("async rst c",     64'(c),     64'h0);
        #3;
        rst = 1'b0;
        check("post rst s_q hold", 64'(s_q), 64'h0);
        @(posedge clk);
        #1;
        check("post rst reload s_q", 64'(s_q), 64'h0000_000F);

        for (int n = 0; n < 512; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 8 == 0) ra[WIDTH-1] = rb[WIDTH-1];
            model(ra, rb, rs, rc, ro);
            apply($sformatf("rand%0d", n), ra, rb, rs, rc, ro);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rca_adder.md
RCA_ADDER -- requirements
Module: rca_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand and sum width in bits; SHALL be legal for any WIDTH >= 1.
REQ-002 Port list, in order:
- clk  input  1  single clock; all registered outputs update on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- a  input  WIDTH  addend A, unsigned (signed view used only for ovf).
- b  input  WIDTH  addend B, same encoding as a.
- s  output  WIDTH  combinational sum a+b modulo 2^WIDTH.
- c  output  1  combinational carry-out of bit WIDTH-1.
- ovf  output  1  combinational two's-complement signed overflow.
- s_q  output  WIDTH  registered copy of s.
- c_q  output  1  registered copy of c.
- ovf_q  output  1  registered copy of ovf.
REQ-003 Output c SHALL be leavable unconnected without affecting s.

Function
REQ-004 Datapath SHALL be a ripple-carry chain of WIDTH 1-bit full adders, built with a generate loop; no behavioural '+' SHALL implement the sum.
REQ-005 Full adder i: s[i] = a[i] ^ b[i] ^ k[i]; k[i+1] = (a[i] & b[i]) | (k[i] & (a[i] ^ b[i])); carry-in k[0] = 0.
REQ-006 c SHALL equal k[WIDTH]; {c, s} SHALL equal the exact (WIDTH+1)-bit unsigned sum of a and b.
REQ-007 ovf SHALL equal k[WIDTH] ^ k[WIDTH-1]; for WIDTH = 1, ovf = k[1] ^ k[0] = c.
REQ-008 s, c, ovf SHALL be purely combinational: zero cycles of latency, no dependence on clk or rst.
REQ-009 s, c, ovf SHALL settle within 15 ns of any input change for WIDTH = 32 at the target corner.
REQ-010 On each rising clk edge with rst low, s_q <= s, c_q <= c, ovf_q <= ovf; latency exactly 1 cycle.
REQ-011 No handshake; a new operand pair is accepted every cycle.
REQ-012 Wrap-around: an all-ones operand plus 1 SHALL give s = 0, c = 1.
REQ-013 Carry SHALL propagate through all WIDTH bits; no stage may be truncated.
REQ-014 X/Z on any operand bit MAY propagate to s, c, ovf; no masking is required.

Reset
REQ-015 While rst = 1, s_q, c_q, ovf_q SHALL be 0 immediately, without waiting for a clk edge.
REQ-016 Asserting rst mid-operation SHALL clear registered outputs asynchronously and SHALL NOT affect s, c, ovf.
REQ-017 After rst deasserts, the first rising clk edge SHALL load the current combinational results.

Verification
REQ-018 a = 0x0000_0003, b = 0x0000_0004 -> s = 0x0000_0007, c = 0, ovf = 0; one clk later s_q = 0x0000_0007.
REQ-019 a = 0xFFFF_FFFF, b = 0x0000_0001 -> s = 0x0000_0000, c = 1, ovf = 0 (full-length carry ripple).
REQ-020 a = 0x7FFF_FFFF, b = 0x0000_0001 -> s = 0x8000_0000, c = 0, ovf = 1.
REQ-021 a = 0x8000_0000, b = 0x8000_0000 -> s = 0x0000_0000, c = 1, ovf = 1.
REQ-022 512 random pairs, each held 15 ns and then checked: {c, s} SHALL equal the (WIDTH+1)-bit sum a + b, and registered outputs SHALL match on the next cycle.
REQ-023 Load a = 0x0000_0005, b = 0x0000_000A, clock once (s_q = 0x0000_000F), then assert rst between edges -> s_q, c_q, ovf_q = 0 at once while s stays 0x0000_000F.
